// File: rtl/fb_scanout_reader.sv
// rtl/fb_scanout_reader.sv - raster scan-out: h/v timing, frame-buffer reads, aligned pixel/sync/de stream
module fb_scanout_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        enable,
    input  logic [19:0] base_addr,
    output logic [19:0] addr0,
    output logic        RE0,
    input  logic [23:0] dataout,
    output logic [7:0]  pix_r,
    output logic [7:0]  pix_g,
    output logic [7:0]  pix_b,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        busy
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW  = $clog2(H_TOTAL);
    localparam int VW  = $clog2(V_TOTAL);
    localparam int HW1 = HW + 1;
    localparam int VW1 = VW + 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW1-1:0] H_ACT   = HW1'(H_ACTIVE);
    localparam logic [HW1-1:0] HS_BEG  = HW1'(H_ACTIVE + H_FP);
    localparam logic [HW1-1:0] HS_END  = HW1'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW1-1:0] V_ACT   = VW1'(V_ACTIVE);
    localparam logic [VW1-1:0] VS_BEG  = VW1'(V_ACTIVE + V_FP);
    localparam logic [VW1-1:0] VS_END  = VW1'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic           SYNC_ACT = (SYNC_POL != 0);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] h_cnt, h_nxt;
    logic [VW-1:0] v_cnt, v_nxt;

    logic [19:0] frame_base;
    logic [19:0] lin_idx;
    logic [19:0] cur_base;
    logic [19:0] cur_idx;

    logic running;
    logic active;
    logic at_origin;
    logic hs_raw;
    logic vs_raw;

    logic de_d1;
    logic hs_d0, hs_d1, hs_q;
    logic vs_d0, vs_d1, vs_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_nxt;
            h_cnt <= h_nxt;
            v_cnt <= v_nxt;
        end
    end

    // Leaving RUN is only possible on the last pixel of the last line
    always_comb begin
        state_nxt = state;
        h_nxt     = h_cnt;
        v_nxt     = v_cnt;
        case (state)
            S_IDLE: begin
                h_nxt = '0;
                v_nxt = '0;
                if (enable) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (h_cnt == H_LAST) begin
                    h_nxt = '0;
                    if (v_cnt == V_LAST) begin
                        v_nxt = '0;
                        if (!enable) state_nxt = S_IDLE;
                    end else begin
                        v_nxt = v_cnt + VW'(1);
                    end
                end else begin
                    h_nxt = h_cnt + HW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign running   = (state == S_RUN);
    assign busy      = running;
    assign active    = running && ({1'b0, h_cnt} < H_ACT) && ({1'b0, v_cnt} < V_ACT);
    assign at_origin = running && (h_cnt == '0) && (v_cnt == '0);
    assign hs_raw    = running && ({1'b0, h_cnt} >= HS_BEG) && ({1'b0, h_cnt} < HS_END);
    assign vs_raw    = running && ({1'b0, v_cnt} >= VS_BEG) && ({1'b0, v_cnt} < VS_END);

    // The first pixel of a frame uses base_addr directly, as it is latched on the same edge
    assign cur_base = at_origin ? base_addr : frame_base;
    assign cur_idx  = at_origin ? 20'd0 : lin_idx;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            frame_base  <= '0;
            lin_idx     <= '0;
            addr0       <= '0;
            RE0         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            RE0         <= active;
            frame_start <= at_origin;
            if (at_origin) frame_base <= base_addr;
            if (active) begin
                addr0   <= cur_base + cur_idx;
                lin_idx <= cur_idx + 20'd1;
            end else if (at_origin) begin
                lin_idx <= '0;
            end
        end
    end

    // RE0 is the first de stage; two more stages line de/syncs up with the registered pixel
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            de_d1 <= 1'b0;
            de    <= 1'b0;
            hs_d0 <= 1'b0;
            hs_d1 <= 1'b0;
            hs_q  <= 1'b0;
            vs_d0 <= 1'b0;
            vs_d1 <= 1'b0;
            vs_q  <= 1'b0;
            pix_r <= '0;
            pix_g <= '0;
            pix_b <= '0;
        end else begin
            de_d1 <= RE0;
            de    <= de_d1;
            hs_d0 <= hs_raw;
            hs_d1 <= hs_d0;
            hs_q  <= hs_d1;
            vs_d0 <= vs_raw;
            vs_d1 <= vs_d0;
            vs_q  <= vs_d1;
            if (de_d1) begin
                {pix_r, pix_g, pix_b} <= dataout;
            end else begin
                {pix_r, pix_g, pix_b} <= 24'd0;
            end
        end
    end

    assign hsync = hs_q ? SYNC_ACT : ~SYNC_ACT;
    assign vsync = vs_q ? SYNC_ACT : ~SYNC_ACT;

endmodule
